bfly11_stage: RTL and testbench

- Radix-2 butterfly stage placed directly downstream of the stage-1 twiddle multiplier (twd_mul10).
- Consumes that block's four 16-lane arrays (sum path and diff path, re/im), one vector per clock, CLK_CNT vectors per frame.
- Within each path, performs a distance-8 butterfly across the 16 lanes with one bit of growth.
- Registers results through a 2-stage pipeline and emits a beat index for the next twiddle stage.

---
 rtl/bfly11_stage_if.sv | 36 +++
 rtl/bfly11_stage.sv | 118 +++++++++++
 tb/tb_bfly11_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bfly11_stage_if.sv
// Bundle between the stage-1 twiddle multiplier output and the distance-8 butterfly stage.
// Latency: none (wires only).
// Backpressure: none; the receiver must take every valid beat.
interface bfly11_stage_if #(
    parameter int WIDTH   = 12,
    parameter int CLK_CNT = 16
);
    localparam int CNT_W = (CLK_CNT > 1) ? $clog2(CLK_CNT) : 1;

    logic                    i_valid;
    logic                    i_clr;
    logic signed [WIDTH-1:0] i_sum_re  [0:15];
    logic signed [WIDTH-1:0] i_sum_im  [0:15];
    logic signed [WIDTH-1:0] i_diff_re [0:15];
    logic signed [WIDTH-1:0] i_diff_im [0:15];

    logic signed [WIDTH:0]   o_sum_re  [0:15];
    logic signed [WIDTH:0]   o_sum_im  [0:15];
    logic signed [WIDTH:0]   o_diff_re [0:15];
    logic signed [WIDTH:0]   o_diff_im [0:15];
    logic                    o_valid;
    logic [CNT_W-1:0]        o_cnt;
    logic                    o_frame_last;

    // Upstream / stimulus side
    modport master (
        output i_valid, i_clr, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        input  o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_valid, o_cnt, o_frame_last
    );

    // Butterfly stage side
    modport slave (
        input  i_valid, i_clr, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        output o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_valid, o_cnt, o_frame_last
    );
endinterface

// File: rtl/bfly11_stage.sv
// Radix-2 distance-8 butterfly over 16 lanes on sum and diff paths, one bit growth, plus beat index.
// Latency: 2 clocks from i_valid to o_valid, 1 vector per clock.
// Backpressure: none; i_clr flushes in-flight valids and the beat counter.
module bfly11_stage #(
    parameter int WIDTH   = 12,
    parameter int CLK_CNT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    bfly11_stage_if.slave bus
);
    localparam int LANES = 16;
    localparam int HALF  = 8;
    localparam int CNT_W = (CLK_CNT > 1) ? $clog2(CLK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CNT - 1);

    // Stage A: captured input vector
    logic signed [WIDTH-1:0] a_sr [LANES];
    logic signed [WIDTH-1:0] a_si [LANES];
    logic signed [WIDTH-1:0] a_dr [LANES];
    logic signed [WIDTH-1:0] a_di [LANES];
    logic                    v_a;

    // Butterfly results (combinational) and stage B registers
    logic signed [WIDTH:0]   bf_sr [LANES];
    logic signed [WIDTH:0]   bf_si [LANES];
    logic signed [WIDTH:0]   bf_dr [LANES];
    logic signed [WIDTH:0]   bf_di [LANES];
    logic signed [WIDTH:0]   q_sr  [LANES];
    logic signed [WIDTH:0]   q_si  [LANES];
    logic signed [WIDTH:0]   q_dr  [LANES];
    logic signed [WIDTH:0]   q_di  [LANES];
    logic                    o_valid_q;
    logic [CNT_W-1:0]        cnt_q;

    function automatic logic signed [WIDTH:0] sx(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    // Stage A: load lanes on i_valid, hold otherwise; a clear drops the colliding input
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_a <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                a_sr[j] <= '0;
                a_si[j] <= '0;
                a_dr[j] <= '0;
                a_di[j] <= '0;
            end
        end else begin
            v_a <= bus.i_valid & ~bus.i_clr;
            if (bus.i_valid) begin
                for (int j = 0; j < LANES; j++) begin
                    a_sr[j] <= bus.i_sum_re[j];
                    a_si[j] <= bus.i_sum_im[j];
                    a_dr[j] <= bus.i_diff_re[j];
                    a_di[j] <= bus.i_diff_im[j];
                end
            end
        end
    end

    // Distance-8 butterfly; operands widened by one bit so the result can never wrap
    always_comb begin
        for (int j = 0; j < HALF; j++) begin
            bf_sr[j]      = sx(a_sr[j]) + sx(a_sr[j+HALF]);
            bf_sr[j+HALF] = sx(a_sr[j]) - sx(a_sr[j+HALF]);
            bf_si[j]      = sx(a_si[j]) + sx(a_si[j+HALF]);
            bf_si[j+HALF] = sx(a_si[j]) - sx(a_si[j+HALF]);
            bf_dr[j]      = sx(a_dr[j]) + sx(a_dr[j+HALF]);
            bf_dr[j+HALF] = sx(a_dr[j]) - sx(a_dr[j+HALF]);
            bf_di[j]      = sx(a_di[j]) + sx(a_di[j+HALF]);
            bf_di[j+HALF] = sx(a_di[j]) - sx(a_di[j+HALF]);
        end
    end

    // Stage B: register results when stage A holds a live vector; clear kills the valid only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid_q <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                q_sr[j] <= '0;
                q_si[j] <= '0;
                q_dr[j] <= '0;
                q_di[j] <= '0;
            end
        end else begin
            o_valid_q <= v_a & ~bus.i_clr;
            if (v_a) begin
                for (int j = 0; j < LANES; j++) begin
                    q_sr[j] <= bf_sr[j];
                    q_si[j] <= bf_si[j];
                    q_dr[j] <= bf_dr[j];
                    q_di[j] <= bf_di[j];
                end
            end
        end
    end

    // Beat index of the vector on the outputs; steps after each emitted beat, wraps per frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (bus.i_clr) begin
            cnt_q <= '0;
        end else if (o_valid_q) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_sum_re     = q_sr;
    assign bus.o_sum_im     = q_si;
    assign bus.o_diff_re    = q_dr;
    assign bus.o_diff_im    = q_di;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_cnt        = cnt_q;
    assign bus.o_frame_last = o_valid_q && (cnt_q == CNT_LAST);
endmodule

// File: tb/tb_bfly11_stage.sv
// Bench for bfly11_stage: directed plan steps plus random traffic against a frame-level model.
// Latency: model expects each accepted vector two edges after it is driven.
// Backpressure: none; every output beat is checked as it appears.
module tb_bfly11_stage;
    localparam int WIDTH   = 12;
    localparam int CLK_CNT = 16;

    logic clk;
    logic rstn;

    bfly11_stage_if #(.WIDTH(WIDTH), .CLK_CNT(CLK_CNT)) bus ();

    bfly11_stage #(.WIDTH(WIDTH), .CLK_CNT(CLK_CNT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Path index: 0 sum_re, 1 sum_im, 2 diff_re, 3 diff_im
    int din  [4][16];
    int pend [4][16];   // most recent vector accepted but not yet emitted
    int expd [4][16];   // value the output lanes must show
    bit pend_acc;       // a vector was accepted on the previous edge
    bit exp_valid;
    bit prev_valid;
    int beats;          // beats emitted since last clear/reset, mod CLK_CNT

    function automatic logic [12:0] obs(input int p, input int j);
        case (p)
            0:       return bus.o_sum_re[j];
            1:       return bus.o_sum_im[j];
            2:       return bus.o_diff_re[j];
            default: return bus.o_diff_im[j];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_lane(input string tag, input int p, input int j, input int e);
        logic [12:0] o13;
        logic [12:0] e13;
        o13 = obs(p, j);
        e13 = 13'(e);
        chk($sformatf("%s p%0d lane%0d", tag, p, j), 32'(o13), 32'(e13));
    endtask

    task automatic check_all(input string tag);
        chk({tag, " o_valid"}, 32'(bus.o_valid), 32'(exp_valid));
        chk({tag, " o_cnt"}, 32'(bus.o_cnt), 32'(beats));
        chk({tag, " o_frame_last"}, 32'(bus.o_frame_last),
            32'(exp_valid && (beats == CLK_CNT - 1)));
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 16; j++)
                chk_lane(tag, p, j, expd[p][j]);
    endtask

    task automatic model_reset();
        pend_acc   = 0;
        exp_valid  = 0;
        prev_valid = 0;
        beats      = 0;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 16; j++) begin
                pend[p][j] = 0;
                expd[p][j] = 0;
            end
    endtask

    // Frame-level view of one clock edge
    task automatic model_edge(input bit v, input bit c);
        if (!rstn) begin
            model_reset();
            return;
        end
        if (c) beats = 0;
        else if (prev_valid) beats = (beats + 1) % CLK_CNT;
        exp_valid = pend_acc && !c;
        if (pend_acc)
            for (int p = 0; p < 4; p++)
                for (int j = 0; j < 8; j++) begin
                    expd[p][j]   = pend[p][j] + pend[p][j+8];
                    expd[p][j+8] = pend[p][j] - pend[p][j+8];
                end
        prev_valid = exp_valid;
        pend_acc   = v && !c;
        if (v)
            for (int p = 0; p < 4; p++)
                for (int j = 0; j < 16; j++)
                    pend[p][j] = din[p][j];
    endtask

    task automatic drive(input bit v, input bit c);
        bus.i_valid = v;
        bus.i_clr   = c;
        for (int j = 0; j < 16; j++) begin
            bus.i_sum_re[j]  = 12'(din[0][j]);
            bus.i_sum_im[j]  = 12'(din[1][j]);
            bus.i_diff_re[j] = 12'(din[2][j]);
            bus.i_diff_im[j] = 12'(din[3][j]);
        end
    endtask

    task automatic step(input bit v, input bit c, input string tag);
        drive(v, c);
        @(posedge clk);
        model_edge(v, c);
        #1;
        check_all(tag);
    endtask

    task automatic zero_din();
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 16; j++) din[p][j] = 0;
    endtask

    task automatic rand_din();
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 16; j++) din[p][j] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clk  = 0;
        rstn = 0;
        zero_din();
        model_reset();
        drive(0, 0);
        #2;
        check_all("reset");
        #10 rstn = 1;

        // Basic butterfly
        din[0][0] = 100;
        din[0][8] = 30;
        din[3][3] = -5;
        din[3][11] = 7;
        step(1, 0, "basic_in");
        step(0, 0, "basic_out");
        chk("basic o_valid", 32'(bus.o_valid), 32'(1));
        chk_lane("basic sum_re0", 0, 0, 130);
        chk_lane("basic sum_re8", 0, 8, 70);
        chk_lane("basic diff_im3", 3, 3, 2);
        chk_lane("basic diff_im11", 3, 11, -12);
        chk("basic o_cnt", 32'(bus.o_cnt), 32'(0));

        // Extremes
        rand_din();
        din[0][2] = -2048;
        din[0][10] = -2048;
        din[1][5] = 2047;
        din[1][13] = -2048;
        step(1, 0, "ext_in");
        step(0, 0, "ext_gap");
        chk_lane("ext sum_re2", 0, 2, -4096);
        chk_lane("ext sum_re10", 0, 10, 0);
        chk_lane("ext sum_im5", 1, 5, -1);
        chk_lane("ext sum_im13", 1, 13, 4095);
        step(0, 0, "ext_idle");

        // Full frame plus wrap
        step(0, 1, "frame_clr");
        for (int k = 0; k < 17; k++) begin
            rand_din();
            step(1, 0, "frame");
        end
        step(0, 0, "frame_tail0");
        chk("frame wrap o_cnt", 32'(bus.o_cnt), 32'(0));
        step(0, 0, "frame_tail1");

        // Gaps 1,0,0,1,1
        step(0, 1, "gap_clr");
        rand_din(); step(1, 0, "gap");
        rand_din(); step(0, 0, "gap");
        rand_din(); step(0, 0, "gap");
        rand_din(); step(1, 0, "gap");
        rand_din(); step(1, 0, "gap");
        step(0, 0, "gap_tail");
        step(0, 0, "gap_tail");
        step(0, 0, "gap_tail");

        // Clear colliding with a valid input while vectors are in flight
        step(0, 1, "clr_pre");
        for (int k = 0; k < 7; k++) begin
            rand_din();
            step(1, 0, "clr_run");
        end
        rand_din();
        step(1, 1, "clr_hit");
        chk("clr o_valid", 32'(bus.o_valid), 32'(0));
        step(0, 0, "clr_flush");
        step(0, 0, "clr_flush");
        rand_din();
        step(1, 0, "clr_next");
        step(0, 0, "clr_next_out");
        chk("clr next o_valid", 32'(bus.o_valid), 32'(1));
        chk("clr next o_cnt", 32'(bus.o_cnt), 32'(0));

        // Async reset mid-frame
        step(0, 1, "rst_pre");
        for (int k = 0; k < 11; k++) begin
            rand_din();
            step(1, 0, "rst_run");
        end
        #3 rstn = 0;
        #1;
        model_reset();
        check_all("async_rst");
        step(0, 0, "rst_hold");
        #2 rstn = 1;
        rand_din();
        step(1, 0, "rst_next");
        step(0, 0, "rst_next_out");
        chk("rst next o_valid", 32'(bus.o_valid), 32'(1));
        chk("rst next o_cnt", 32'(bus.o_cnt), 32'(0));

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            rand_din();
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
